// File: rtl/cal_pkg.sv
// Shared calendar constants, field-select encoding and BCD helpers.
// February length depends on CALENDAR_LEAP_EN: 29 in leap years when defined, otherwise always 28.
package cal_pkg;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    localparam logic [7:0] SEC_MIN  = 8'h00;
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MIN  = 8'h00;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MIN = 8'h00;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] DAY_MIN  = 8'h01;
    localparam logic [7:0] DAY_MAX  = 8'h31;
    localparam logic [7:0] MON_MIN  = 8'h01;
    localparam logic [7:0] MON_MAX  = 8'h12;

    typedef enum logic [2:0] {
        SEL_SEC  = 3'd0,
        SEL_MIN  = 3'd1,
        SEL_HOUR = 3'd2,
        SEL_DAY  = 3'd3,
        SEL_MON  = 3'd4,
        SEL_YEAR = 3'd5
    } sel_e;

    function automatic logic digits_ok(input logic [7:0] v);
        return (v[7:4] <= DIGIT_MAX) && (v[3:0] <= DIGIT_MAX);
    endfunction

    // Digit-wise increment with wrap from mx back to mn.
    function automatic logic [7:0] bcd2_next(input logic [7:0] v, input logic [7:0] mn,
                                             input logic [7:0] mx);
        if (v == mx)
            return mn;
        if (v[3:0] == DIGIT_MAX)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] sanitise(input logic [7:0] v, input logic [7:0] mn,
                                            input logic [7:0] mx);
        return (digits_ok(v) && v >= mn && v <= mx) ? v : mn;
    endfunction

    function automatic logic [7:0] clamp_day(input logic [7:0] d, input logic [7:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Two BCD digits divisible by 4: even tens need units 0/4/8, odd tens need 2/6.
    function automatic logic div4(input logic [7:0] v);
        if (v[4])
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    function automatic logic is_leap(input logic [15:0] y);
`ifdef CALENDAR_LEAP_EN
        return (y[7:0] == 8'h00) ? div4(y[15:8]) : div4(y[7:0]);
`else
        return 1'b0 & y[0];
`endif
    endfunction

    function automatic logic [7:0] dim(input logic [7:0] mon, input logic [15:0] y);
        case (mon)
            8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/bcd2_field.sv
// Two-digit BCD counter with runtime min/max, increment, load and wrap flag.
module bcd2_field
    import cal_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       wrap
);

    assign wrap = inc && !load && (value == max_val);

    always_ff @(posedge clk) begin
        if (!rst_n)
            value <= min_val;
        else if (load)
            value <= load_val;
        else if (inc)
            value <= bcd2_next(value, min_val, max_val);
    end

endmodule

// File: rtl/bcd_calendar_chain.sv
// BCD sec/min/hour/day/month/year chain with load sanitising and per-field setting.
// Leap-year February handling is enabled by defining CALENDAR_LEAP_EN.
module bcd_calendar_chain
    import cal_pkg::*;
#(
    parameter int YEAR_DIGITS = 4,
    localparam int YW = 4 * YEAR_DIGITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          load_en,
    input  logic [7:0]    load_sec,
    input  logic [7:0]    load_min,
    input  logic [7:0]    load_hour,
    input  logic [7:0]    load_day,
    input  logic [7:0]    load_mon,
    input  logic [YW-1:0] load_year,
    input  logic          set_inc,
    input  logic [2:0]    set_sel,
    output logic [7:0]    sec,
    output logic [7:0]    min,
    output logic [7:0]    hour,
    output logic [7:0]    day,
    output logic [7:0]    mon,
    output logic [YW-1:0] year,
    output logic [5:0]    carry_out
);

    function automatic logic [15:0] ext16(input logic [YW-1:0] y);
        logic [15:0] r;
        r = '0;
        r[YW-1:0] = y;
        return r;
    endfunction

    sel_e sel;
    logic tick_go, set_go;
    logic sec_inc, min_inc, hour_inc, day_inc, mon_inc, year_inc;
    logic sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap, year_wrap;
    logic [7:0] day_lim, day_ld_val, mon_s, day_s;
    logic day_ld;
    logic [YW-1:0] year_step, year_s;
    logic [YEAR_DIGITS:0] ycarry;
    logic [YEAR_DIGITS-1:0] ynib_ok;

    assign sel     = sel_e'(set_sel);
    assign set_go  = set_inc && !load_en;
    assign tick_go = tick && !load_en && !set_inc;

    // Whole chain resolves combinationally so one tick can roll every field.
    assign sec_inc  = tick_go                || (set_go && sel == SEL_SEC);
    assign min_inc  = (tick_go && sec_wrap)  || (set_go && sel == SEL_MIN);
    assign hour_inc = (tick_go && min_wrap)  || (set_go && sel == SEL_HOUR);
    assign day_inc  = (tick_go && hour_wrap) || (set_go && sel == SEL_DAY);
    assign mon_inc  = (tick_go && day_wrap)  || (set_go && sel == SEL_MON);
    assign year_inc = (tick_go && mon_wrap)  || (set_go && sel == SEL_YEAR);

    assign day_lim = dim(mon, ext16(year));
    assign mon_s   = sanitise(load_mon, MON_MIN, MON_MAX);
    assign day_s   = sanitise(load_day, DAY_MIN, DAY_MAX);
    assign year_s  = (&ynib_ok) ? load_year : '0;

    always_comb begin
        day_ld     = 1'b0;
        day_ld_val = day;
        if (load_en) begin
            day_ld     = 1'b1;
            day_ld_val = clamp_day(day_s, dim(mon_s, ext16(year_s)));
        end else if (set_go && sel == SEL_MON) begin
            day_ld     = 1'b1;
            day_ld_val = clamp_day(day, dim(bcd2_next(mon, MON_MIN, MON_MAX), ext16(year)));
        end else if (set_go && sel == SEL_YEAR) begin
            day_ld     = 1'b1;
            day_ld_val = clamp_day(day, dim(mon, ext16(year_step)));
        end
    end

    bcd2_field u_sec (
        .clk(clk), .rst_n(rst_n), .min_val(SEC_MIN), .max_val(SEC_MAX), .inc(sec_inc),
        .load(load_en), .load_val(sanitise(load_sec, SEC_MIN, SEC_MAX)),
        .value(sec), .wrap(sec_wrap)
    );
    bcd2_field u_min (
        .clk(clk), .rst_n(rst_n), .min_val(MIN_MIN), .max_val(MIN_MAX), .inc(min_inc),
        .load(load_en), .load_val(sanitise(load_min, MIN_MIN, MIN_MAX)),
        .value(min), .wrap(min_wrap)
    );
    bcd2_field u_hour (
        .clk(clk), .rst_n(rst_n), .min_val(HOUR_MIN), .max_val(HOUR_MAX), .inc(hour_inc),
        .load(load_en), .load_val(sanitise(load_hour, HOUR_MIN, HOUR_MAX)),
        .value(hour), .wrap(hour_wrap)
    );
    bcd2_field u_day (
        .clk(clk), .rst_n(rst_n), .min_val(DAY_MIN), .max_val(day_lim), .inc(day_inc),
        .load(day_ld), .load_val(day_ld_val), .value(day), .wrap(day_wrap)
    );
    bcd2_field u_mon (
        .clk(clk), .rst_n(rst_n), .min_val(MON_MIN), .max_val(MON_MAX), .inc(mon_inc),
        .load(load_en), .load_val(mon_s), .value(mon), .wrap(mon_wrap)
    );

    assign ycarry[0] = year_inc;
    for (genvar g = 0; g < YEAR_DIGITS; g++) begin : g_year
        logic [3:0] d;
        assign d                    = year[4*g +: 4];
        assign year_step[4*g +: 4]  = !ycarry[g] ? d : ((d == DIGIT_MAX) ? 4'd0 : d + 4'd1);
        assign ycarry[g+1]          = ycarry[g] && (d == DIGIT_MAX);
        assign ynib_ok[g]           = load_year[4*g +: 4] <= DIGIT_MAX;
    end
    assign year_wrap = ycarry[YEAR_DIGITS];

    always_ff @(posedge clk) begin
        if (!rst_n)
            year <= '0;
        else if (load_en)
            year <= year_s;
        else
            year <= year_step;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            carry_out <= '0;
        else if (tick_go)
            carry_out <= {year_wrap, mon_wrap, day_wrap, hour_wrap, min_wrap, sec_wrap};
        else
            carry_out <= '0;
    end

endmodule

// File: tb/tb_bcd_calendar_chain.sv
// Self-checking bench: random tick/load/set traffic against an integer calendar model.
module tb_bcd_calendar_chain;

    logic        clk = 1'b0;
    logic        rst_n, tick, load_en, set_inc;
    logic [7:0]  load_sec, load_min, load_hour, load_day, load_mon;
    logic [15:0] load_year;
    logic [2:0]  set_sel;
    logic [7:0]  sec, min, hour, day, mon;
    logic [15:0] year;
    logic [5:0]  carry_out;

    int checks = 0;
    int errors = 0;
    int m_sec, m_min, m_hour, m_day, m_mon, m_year;
    logic [5:0] m_carry;

    always #5 clk = ~clk;

    bcd_calendar_chain #(.YEAR_DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load_en(load_en),
        .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
        .load_day(load_day), .load_mon(load_mon), .load_year(load_year),
        .set_inc(set_inc), .set_sel(set_sel),
        .sec(sec), .min(min), .hour(hour), .day(day), .mon(mon), .year(year),
        .carry_out(carry_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] i2b8(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [15:0] i2b16(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int san(input logic [7:0] v, input int lo, input int hi);
        int n;
        if (v[7:4] > 9 || v[3:0] > 9) return lo;
        n = v[7:4] * 10 + v[3:0];
        return (n < lo || n > hi) ? lo : n;
    endfunction

    function automatic int san_year(input logic [15:0] v);
        int n = 0;
        for (int i = 3; i >= 0; i--) begin
            if (v[4*i +: 4] > 9) return 0;
            n = n * 10 + int'(v[4*i +: 4]);
        end
        return n;
    endfunction

    function automatic bit leap(input int y);
`ifdef CALENDAR_LEAP_EN
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
`else
        return (y < 0);
`endif
    endfunction

    function automatic int mdim(input int m, input int y);
        case (m)
            2:             return leap(y) ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    task automatic clamp_model_day();
        if (m_day > mdim(m_mon, m_year)) m_day = mdim(m_mon, m_year);
    endtask

    task automatic model_step();
        m_carry = '0;
        if (!rst_n) begin
            m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 0;
        end else if (load_en) begin
            m_sec  = san(load_sec, 0, 59);
            m_min  = san(load_min, 0, 59);
            m_hour = san(load_hour, 0, 23);
            m_mon  = san(load_mon, 1, 12);
            m_year = san_year(load_year);
            m_day  = san(load_day, 1, 31);
            clamp_model_day();
        end else if (set_inc) begin
            case (set_sel)
                3'd0: m_sec  = (m_sec + 1) % 60;
                3'd1: m_min  = (m_min + 1) % 60;
                3'd2: m_hour = (m_hour + 1) % 24;
                3'd3: m_day  = (m_day >= mdim(m_mon, m_year)) ? 1 : m_day + 1;
                3'd4: begin m_mon = m_mon % 12 + 1; clamp_model_day(); end
                3'd5: begin m_year = (m_year + 1) % 10000; clamp_model_day(); end
                default: ;
            endcase
        end else if (tick) begin
            m_sec++;
            if (m_sec == 60) begin
                m_sec = 0; m_carry[0] = 1'b1; m_min++;
                if (m_min == 60) begin
                    m_min = 0; m_carry[1] = 1'b1; m_hour++;
                    if (m_hour == 24) begin
                        m_hour = 0; m_carry[2] = 1'b1; m_day++;
                        if (m_day > mdim(m_mon, m_year)) begin
                            m_day = 1; m_carry[3] = 1'b1; m_mon++;
                            if (m_mon == 13) begin
                                m_mon = 1; m_carry[4] = 1'b1; m_year++;
                                if (m_year == 10000) begin
                                    m_year = 0; m_carry[5] = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Inputs are held across the edge, outputs compared 1 ns after it, then pulses cleared.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_eq("sec",   sec,       i2b8(m_sec));
        check_eq("min",   min,       i2b8(m_min));
        check_eq("hour",  hour,      i2b8(m_hour));
        check_eq("day",   day,       i2b8(m_day));
        check_eq("mon",   mon,       i2b8(m_mon));
        check_eq("year",  year,      i2b16(m_year));
        check_eq("carry", carry_out, m_carry);
        tick = 0; load_en = 0; set_inc = 0;
    endtask

    task automatic do_load(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                           input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        load_year = y; load_mon = mo; load_day = d;
        load_hour = h; load_min = mi; load_sec = s;
        load_en = 1;
        step();
    endtask

    initial begin
        rst_n = 0; tick = 0; load_en = 0; set_inc = 0; set_sel = '0;
        load_sec = '0; load_min = '0; load_hour = '0; load_day = '0; load_mon = '0; load_year = '0;
        step();
        step();
        rst_n = 1;
        step();
        check_eq("rst_date",  {year, mon, day}, 32'h0000_0101);
        check_eq("rst_time",  {hour, min, sec}, 32'h0);
        check_eq("rst_carry", carry_out, 6'b0);

        do_load(16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
        tick = 1; step();
        check_eq("ny_date",  {year, mon, day}, 32'h2024_0101);
        check_eq("ny_time",  {hour, min, sec}, 32'h0);
        check_eq("ny_carry", carry_out, 6'b011111);
        step();
        check_eq("ny_carry_clr", carry_out, 6'b0);

        do_load(16'h2024, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
        tick = 1; step();
`ifdef CALENDAR_LEAP_EN
        check_eq("leap2024", {year, mon, day}, 32'h2024_0229);
`else
        check_eq("leap2024", {year, mon, day}, 32'h2024_0301);
`endif
        do_load(16'h2100, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
        tick = 1; step();
        check_eq("feb2100", {year, mon, day}, 32'h2100_0301);

        do_load(16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
        tick = 1; step();
        check_eq("y_wrap_date",  {year, mon, day}, 32'h0000_0101);
        check_eq("y_wrap_carry", carry_out, 6'b111111);

        do_load(16'h2023, 8'h04, 8'h31, 8'h10, 8'h20, 8'h7A);
        check_eq("ld_clamp_day", day, 8'h30);
        check_eq("ld_bad_sec",   sec, 8'h00);
        do_load(16'h2023, 8'h01, 8'h31, 8'h00, 8'h00, 8'h59);
        set_inc = 1; set_sel = 3'd4; step();
        check_eq("set_mon_clamp", {year, mon, day}, 32'h2023_0228);

        tick = 1;
        do_load(16'h1999, 8'h06, 8'h15, 8'h12, 8'h34, 8'h56);
        check_eq("ld_over_tick", {hour, min, sec}, 32'h0012_3456);
        do_load(16'h1999, 8'h06, 8'h15, 8'h12, 8'h34, 8'h59);
        set_inc = 1; set_sel = 3'd0; tick = 1; step();
        check_eq("set_sec_wrap", {hour, min, sec}, 32'h0012_3400);
        check_eq("set_no_carry", carry_out, 6'b0);

        for (int n = 0; n < 5000; n++) begin
            int pick;
            rst_n   = ($urandom_range(0, 999) != 0);
            tick    = ($urandom_range(0, 99) < 70);
            set_inc = ($urandom_range(0, 19) == 0);
            set_sel = 3'($urandom_range(0, 7));
            load_en = ($urandom_range(0, 39) == 0);
            if (load_en) begin
                load_sec  = i2b8($urandom_range(55, 59));
                load_min  = i2b8($urandom_range(57, 59));
                load_hour = i2b8($urandom_range(22, 23));
                load_day  = i2b8($urandom_range(26, 31));
                load_mon  = i2b8($urandom_range(1, 12));
                pick = $urandom_range(0, 6);
                case (pick)
                    0: load_year = 16'h9999;
                    1: load_year = 16'h2000;
                    2: load_year = 16'h2100;
                    3: load_year = 16'h2024;
                    4: load_year = 16'h2400;
                    default: load_year = i2b16($urandom_range(0, 9999));
                endcase
                if ($urandom_range(0, 7) == 0) load_sec  = 8'($urandom);
                if ($urandom_range(0, 7) == 0) load_day  = 8'($urandom);
                if ($urandom_range(0, 7) == 0) load_mon  = 8'($urandom);
                if ($urandom_range(0, 7) == 0) load_hour = 8'($urandom);
                if ($urandom_range(0, 9) == 0) load_year = 16'($urandom);
            end
            step();
            rst_n = 1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
